// File: rtl/debug_view_seq_if.sv
// Read-address bus toward the debug sources and the captured display word toward the 7-seg driver.
// The master side (sequencer) drives the address, source index and display fields; the slave side returns read data.
interface debug_view_seq_if #(
  parameter int N_SRC  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [ADDR_W-1:0]       rd_addr_o;
  logic [SRC_W-1:0]        rd_src_o;
  logic [N_SRC*DATA_W-1:0] rd_data_i;
  logic [DATA_W-1:0]       disp_data_o;
  logic [ADDR_W-1:0]       disp_addr_o;
  logic                    disp_valid_o;

  modport master (
    output rd_addr_o, rd_src_o, disp_data_o, disp_addr_o, disp_valid_o,
    input  rd_data_i
  );

  modport slave (
    input  rd_addr_o, rd_src_o, disp_data_o, disp_addr_o, disp_valid_o,
    output rd_data_i
  );
endinterface

// File: rtl/debug_view_seq.sv
// Debug-view sequencer: scans a read address through one of N_SRC sources and captures each word for display.
// Capture 1 clk after a tick/step; no backpressure. DVS_STEP_EN adds run/single-step control via step_i.
module debug_view_seq #(
  parameter int DIV_FAST   = 25,
  parameter int DIV_SLOW   = 27,
  parameter int N_SRC      = 4,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int SCAN_DEPTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rate_i,
  input  logic [N_SRC-1:0] src_sel_i,
  input  logic             run_i,
  input  logic             step_i,
  output logic             tick_o,
  debug_view_seq_if.master bus
);
  localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [DIV_SLOW:0] presc;
  logic              sel_bit;
  logic              sel_q;
  logic [SRC_W-1:0]  dec_idx;
  logic              src_chg;
  logic              adv;
  logic              cap;

  // Tick is the rising edge of the chosen prescaler bit; a rate switch may cost one spurious tick.
  assign sel_bit = rate_i ? presc[DIV_SLOW] : presc[DIV_FAST];
  assign tick_o  = sel_bit & ~sel_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc <= '0;
      sel_q <= 1'b0;
    end else begin
      presc <= presc + 1'b1;
      sel_q <= sel_bit;
    end
  end

  // Zero or multi-hot selects fall back to source 0.
  always_comb begin
    dec_idx = '0;
    if ($countones(src_sel_i) == 1) begin
      for (int k = 0; k < N_SRC; k++) begin
        if (src_sel_i[k]) dec_idx = SRC_W'(k);
      end
    end
  end

  assign src_chg = (dec_idx != bus.rd_src_o);

`ifdef DVS_STEP_EN
  logic [2:0] step_sync;
  logic       step_p;

  assign step_p = step_sync[1] & ~step_sync[2];
  assign adv    = run_i ? tick_o : step_p;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) step_sync <= '0;
    else       step_sync <= {step_sync[1:0], step_i};
  end
`else
  logic unused_step_ctrl;
  assign unused_step_ctrl = step_i ^ run_i;
  assign adv = tick_o;
`endif

  // A source change takes priority over a coincident advance.
  assign cap = adv & ~src_chg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.rd_addr_o    <= '0;
      bus.rd_src_o     <= '0;
      bus.disp_data_o  <= '0;
      bus.disp_addr_o  <= '0;
      bus.disp_valid_o <= 1'b0;
    end else begin
      bus.disp_valid_o <= cap;
      if (src_chg) begin
        bus.rd_src_o  <= dec_idx;
        bus.rd_addr_o <= '0;
      end else if (cap) begin
        bus.disp_data_o <= bus.rd_data_i[bus.rd_src_o*DATA_W +: DATA_W];
        bus.disp_addr_o <= bus.rd_addr_o;
        if (bus.rd_addr_o == ADDR_W'(SCAN_DEPTH-1)) bus.rd_addr_o <= '0;
        else                                        bus.rd_addr_o <= bus.rd_addr_o + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_debug_view_seq.sv
// Directed bench for debug_view_seq with a capture scoreboard; source k returns 32'hk000_0000 + addr.
module tb_debug_view_seq;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rate_i = 1'b0;
  logic [3:0] src_sel_i = 4'b0001;
  logic       run_i = 1'b1;
  logic       step_i = 1'b0;
  logic       tick_o;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  addr;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  debug_view_seq_if #(.N_SRC(4), .DATA_W(32), .ADDR_W(5)) bus ();

  debug_view_seq #(
    .DIV_FAST(2), .DIV_SLOW(4), .N_SRC(4), .DATA_W(32), .ADDR_W(5), .SCAN_DEPTH(4)
  ) dut (
    .clk(clk), .rstn(rstn), .rate_i(rate_i), .src_sel_i(src_sel_i),
    .run_i(run_i), .step_i(step_i), .tick_o(tick_o), .bus(bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.rd_data_i = '0;
    for (int k = 0; k < 4; k++) bus.rd_data_i[k*32 +: 32] = (32'(k) << 28) + 32'(bus.rd_addr_o);
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [4:0] a);
    q.push_back({d, a});
  endtask

  always @(negedge clk) begin
    if (rstn && bus.disp_valid_o) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL capture_unexpected: got data %h addr %0d, none expected (cyc %0d)",
                 bus.disp_data_o, bus.disp_addr_o, cyc);
      end else begin
        mon_e = q.pop_front();
        check("capture_data", bus.disp_data_o, mon_e.data);
        check("capture_addr", 32'(bus.disp_addr_o), 32'(mon_e.addr));
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_rd_addr"},   32'(bus.rd_addr_o),    32'd0);
    check({tag, "_rd_src"},    32'(bus.rd_src_o),     32'd0);
    check({tag, "_disp_data"}, bus.disp_data_o,       32'd0);
    check({tag, "_disp_addr"}, 32'(bus.disp_addr_o),  32'd0);
    check({tag, "_disp_vld"},  32'(bus.disp_valid_o), 32'd0);
    check({tag, "_tick"},      32'(tick_o),           32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check_zero("reset");
    rstn = 1'b1;
  endtask

  // Advances to 1 ns after the posedge that makes cyc == t.
  task automatic wait_cyc(input int t);
    int g = 0;
    while (cyc != t && g < 300) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (cyc != t) check("wait_cyc_timeout", 32'(cyc), 32'(t));
  endtask

  initial begin
    // Fast rate: first tick after 4 clk, then every 8.
    rate_i = 1'b0; src_sel_i = 4'b0001; run_i = 1'b1;
    do_reset();
    push(32'h0000_0000, 5'd0); push(32'h0000_0001, 5'd1); push(32'h0000_0002, 5'd2);
    for (int n = 1; n <= 24; n++) begin
      @(posedge clk); #1;
      check("tick_fast", 32'(tick_o), 32'(n % 8 == 4));
    end
    check("fast_queue_drained", 32'(q.size()), 32'd0);

    // Slow rate: first tick after 16 clk, then every 32.
    rate_i = 1'b1;
    do_reset();
    push(32'h0000_0000, 5'd0); push(32'h0000_0001, 5'd1);
    for (int n = 1; n <= 64; n++) begin
      @(posedge clk); #1;
      check("tick_slow", 32'(tick_o), 32'(n % 32 == 16));
    end
    check("slow_queue_drained", 32'(q.size()), 32'd0);

    // Auto-scan wrap on source 2, switch to 3 on a tick, then invalid selects.
    rate_i = 1'b0; src_sel_i = 4'b0100;
    do_reset();
    push(32'h2000_0000, 5'd0); push(32'h2000_0001, 5'd1); push(32'h2000_0002, 5'd2);
    push(32'h2000_0003, 5'd3); push(32'h2000_0000, 5'd0); push(32'h2000_0001, 5'd1);
    push(32'h3000_0000, 5'd0);
    push(32'h0000_0000, 5'd0); push(32'h0000_0001, 5'd1); push(32'h0000_0002, 5'd2);
    wait_cyc(2);
    check("src2_rd_src", 32'(bus.rd_src_o), 32'd2);
    wait_cyc(52);
    check("switch_tick", 32'(tick_o), 32'd1);
    check("switch_pre_addr", 32'(bus.rd_addr_o), 32'd2);
    src_sel_i = 4'b1000;
    wait_cyc(53);
    check("switch_no_valid", 32'(bus.disp_valid_o), 32'd0);
    check("switch_rd_addr", 32'(bus.rd_addr_o), 32'd0);
    check("switch_rd_src", 32'(bus.rd_src_o), 32'd3);
    check("switch_hold_data", bus.disp_data_o, 32'h2000_0001);
    wait_cyc(62);
    src_sel_i = 4'b0110;
    wait_cyc(63);
    check("multihot_rd_src", 32'(bus.rd_src_o), 32'd0);
    check("multihot_rd_addr", 32'(bus.rd_addr_o), 32'd0);
    wait_cyc(70);
    src_sel_i = 4'b0000;
    wait_cyc(86);
    check("zero_sel_rd_src", 32'(bus.rd_src_o), 32'd0);
    check("pre_reset_addr", 32'(bus.rd_addr_o), 32'd3);
    check("pre_reset_data", bus.disp_data_o, 32'h0000_0002);
    check("scan_queue_drained", 32'(q.size()), 32'd0);

    // Asynchronous reset between clock edges.
    #2;
    rstn = 1'b0;
    #1;
    check_zero("async_reset");

`ifdef DVS_STEP_EN
    // Single-step: three 5-clk step pulses, ticks ignored.
    rate_i = 1'b0; src_sel_i = 4'b0001; run_i = 1'b0;
    do_reset();
    push(32'h0000_0000, 5'd0); push(32'h0000_0001, 5'd1); push(32'h0000_0002, 5'd2);
    for (int s = 10; s <= 30; s += 10) begin
      wait_cyc(s);
      step_i = 1'b1;
      wait_cyc(s + 2);
      check("step_not_yet", 32'(bus.disp_valid_o), 32'd0);
      wait_cyc(s + 3);
      check("step_valid", 32'(bus.disp_valid_o), 32'd1);
      wait_cyc(s + 5);
      step_i = 1'b0;
    end
    wait_cyc(45);
    check("step_queue_drained", 32'(q.size()), 32'd0);
    check("step_rd_addr", 32'(bus.rd_addr_o), 32'd3);
`endif

    check("final_queue_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/debug_view_seq.md
# debug_view_seq

Parametrised debug-view sequencer for the board's 7-segment debug path. It replaces the hard-wired clock-bit CPU divider and the per-source address steppers for the ROM, register file, ALU and data memory views with one block. The block picks one of N_SRC debug sources and walks a read address through it at a switch-selectable rate or one step at a time. It captures each read word into a registered display word that feeds the 7-segment driver. Everything runs on the board clock with single-cycle tick enables; no derived clocks are produced.

## Interface
- DIV_FAST, 25: prescaler bit index used for the fast scan rate.
- DIV_SLOW, 27: prescaler bit index used for the slow scan rate; must be greater than or equal to DIV_FAST.
- N_SRC, 4: number of debug sources.
- DATA_W, 32: width of each source word.
- ADDR_W, 5: width of the read address.
- SCAN_DEPTH, 32: number of addresses scanned per source, 2..2^ADDR_W.

Ports:
- clk, input, 1: board clock.
- rstn, input, 1: reset, asynchronous, active-low.
- rate_i, input, 1: 1 selects the slow rate (DIV_SLOW), 0 selects the fast rate (DIV_FAST).
- src_sel_i, input, N_SRC: one-hot source select.
- run_i, input, 1: 1 = auto-scan, 0 = single-step mode.
- step_i, input, 1: raw switch or button input; each rising edge gives one step.
- rd_data_i, input, N_SRC*DATA_W: combinational read data; source k occupies bits [k*DATA_W +: DATA_W].
- rd_addr_o, output, ADDR_W: current read address, shared by all sources.
- rd_src_o, output, clog2(N_SRC): index of the active source.
- disp_data_o, output, DATA_W: captured display word.
- disp_addr_o, output, ADDR_W: address that disp_data_o was read from.
- disp_valid_o, output, 1: one-cycle pulse when disp_data_o updates.
- tick_o, output, 1: one-cycle scan-rate tick; exported so other blocks can use it as a clock enable.

## Operation
- Prescaler: a free-running counter of DIV_SLOW+1 bits.
  - The selected bit (DIV_FAST or DIV_SLOW, chosen by rate_i) is registered once.
  - tick_o = selected bit is 1 AND the registered copy is 0 (rising edge of the selected bit).
  - When rate_i changes, the new bit is used from the next cycle. At most one spurious tick may occur; this is acceptable.
- Source decode:
  - If src_sel_i is exactly one-hot, the active index is the position of its set bit.
  - If src_sel_i is zero or multi-hot, the active index is 0.
  - rd_src_o is the registered active index.
- Step input: step_i passes through a 2-FF synchroniser, then a rising-edge detector, producing step_p.
- Advance condition: adv = (run_i & tick_o) | (~run_i & step_p).
  - In run mode, step_p is ignored.
  - In step mode, ticks are ignored.
- On an adv cycle with no source change:
  - disp_data_o <= the active slice of rd_data_i at the current rd_addr_o.
  - disp_addr_o <= rd_addr_o.
  - disp_valid_o <= 1.
  - rd_addr_o <= 0 if rd_addr_o == SCAN_DEPTH-1, else rd_addr_o + 1.
- Source change: when the decoded index differs from rd_src_o, in the same cycle:
  - rd_src_o is updated.
  - rd_addr_o <= 0.
  - adv is suppressed: no capture, and disp_valid_o = 0.
  - disp_data_o holds its old value.
  - If the change coincides with adv, the source change wins.
- Address range: rd_addr_o never reaches SCAN_DEPTH or above.

## Timing
- Reset values:
  - rd_addr_o = 0, rd_src_o = 0.
  - disp_data_o = 0, disp_addr_o = 0, disp_valid_o = 0.
  - tick_o = 0.
  - Prescaler = 0, synchroniser and edge-detect flops = 0.
- Tick period: 2^(DIV+1) clk cycles, where DIV is the selected bit index. The first tick arrives 2^DIV cycles after reset release.
- Capture latency: disp_data_o, disp_addr_o and disp_valid_o update on the clock edge that ends the adv cycle, i.e. 1 clk after tick_o or step_p is high.
- rd_data_i must settle within one clk of a change on rd_addr_o or rd_src_o.
- Step latency: 3 clk from a step_i rising edge to disp_valid_o (2 synchroniser stages, then the capture edge).
- Reset asserted mid-scan: all state clears asynchronously. The scan restarts at address 0 of source 0; any step edge in the synchroniser is lost.

## Configuration
- DVS_STEP_EN:
  - Defined: single-step mode, the synchroniser and the edge detector are compiled in, as described above.
  - Undefined: step logic is removed and step_i is unused. run_i is also ignored and the block always auto-scans: adv = tick_o.

## Test plan
Parameters for all scenarios: DIV_FAST=2, DIV_SLOW=4, SCAN_DEPTH=4, N_SRC=4, DATA_W=32, ADDR_W=5. rd_data_i slice k returns 32'hk000_0000 + addr.

- Fast-rate tick: rstn released, rate_i=0 -> tick_o pulses every 8 clk, first pulse 4 clk after release. Slow rate (rate_i=1) -> a pulse every 32 clk.
- Auto-scan wrap: run_i=1, src_sel_i=4'b0100 -> disp_data_o sequence 32'h2000_0000, _0001, _0002, _0003, then _0000 again; disp_addr_o follows 0..3 then 0.
- Source switch mid-scan: at address 2, set src_sel_i=4'b1000 at the same time as a tick -> no disp_valid_o that cycle, rd_addr_o=0, rd_src_o=3; the next capture is 32'h3000_0000.
- Invalid select: src_sel_i=4'b0110 and then 4'b0000 -> rd_src_o=0 and captures are from source 0.
- Step mode (DVS_STEP_EN defined): run_i=0, three step_i pulses of 5 clk each -> exactly three disp_valid_o pulses, each 3 clk after a step_i rise, addresses 0, 1, 2; no captures from ticks in between.
- Async reset mid-scan: pull rstn low between clock edges while at address 3 -> all outputs go to 0 immediately, without waiting for a clock edge.
